// File: rtl/updown_mod_counter_pkg.sv
// Shared constants and helpers for the up/down modulo counter family.
// Latency: n/a (package only). Backpressure: n/a.
// Optional feature macro used by this family: CNT_PRESCALE_EN.
package cnt_pkg;

    localparam logic CNT_UP   = 1'b1;
    localparam logic CNT_DOWN = 1'b0;
    localparam logic CNT_WRAP = 1'b0;
    localparam logic CNT_SAT  = 1'b1;

    // Bits needed to hold 0..n-1, never less than one so PRESCALE=1 still elaborates.
    function automatic int cnt_clog2w(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/updown_mod_counter_if.sv
// Control/status bundle of the up/down modulo counter.
// Latency: n/a (wires only). Backpressure: none, purely level-driven controls.
// Feature macro CNT_PRESCALE_EN does not change this bundle.
interface updown_mod_counter_if #(
    parameter int WIDTH = 4
);

    logic             enable;
    logic             up_down;
    logic             mode_sat;
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic             clear_ovf;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             ovf;

    modport master (
        output enable, up_down, mode_sat, load, load_value, clear_ovf,
        input  count, tc, ovf
    );

    modport slave (
        input  enable, up_down, mode_sat, load, load_value, clear_ovf,
        output count, tc, ovf
    );

endinterface

// File: rtl/updown_mod_counter_prescaler.sv
// Divides enabled cycles by PRESCALE; tick is high on the last phase while enabled.
// Latency: tick is combinational from the registered phase and enable.
// Backpressure: phase holds while enable=0; clear restarts the phase at 0.
module cnt_prescaler
    import cnt_pkg::*;
#(
    parameter int PRESCALE = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int              PW   = cnt_clog2w(PRESCALE);
    localparam logic [PW-1:0]   LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] r_phase;
    logic          w_last;

    assign w_last = (r_phase == LAST);
    assign tick   = enable & w_last;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_phase <= '0;
        end else if (clear) begin
            r_phase <= '0;
        end else if (enable) begin
            r_phase <= w_last ? '0 : r_phase + PW'(1);
        end
    end

endmodule

// File: rtl/updown_mod_counter.sv
// Up/down modulo counter with load clamp, wrap/saturate, registered tc and sticky ovf.
// Latency: 1 cycle for reset/load/step; no input-to-output combinational path.
// Backpressure: none; enable=0 holds state. Macro CNT_PRESCALE_EN adds a step prescaler.
module updown_mod_counter
    import cnt_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int MAX      = 2**WIDTH - 1
`ifdef CNT_PRESCALE_EN
    ,
    parameter int PRESCALE = 4
`endif
) (
    input  logic                  clk,
    input  logic                  reset,
    updown_mod_counter_if.slave   bus
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    logic [WIDTH-1:0] r_count;
    logic             r_tc;
    logic             r_ovf;

    logic             w_tick;
    logic             w_step;
    logic             w_at_max;
    logic             w_at_zero;
    logic             w_boundary;
    logic [WIDTH-1:0] w_load_clamped;
    logic [WIDTH-1:0] w_count_nxt;
    logic             w_ovf_nxt;

`ifdef CNT_PRESCALE_EN
    cnt_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk    (clk),
        .reset  (reset),
        .enable (bus.enable & ~bus.load),
        .clear  (bus.load),
        .tick   (w_tick)
    );
`else
    assign w_tick = 1'b1;
`endif

    always_comb begin
        w_at_max       = (r_count == MAX_V);
        w_at_zero      = (r_count == '0);
        w_step         = bus.enable & ~bus.load & w_tick;
        w_load_clamped = (bus.load_value > MAX_V) ? MAX_V : bus.load_value;
        w_boundary     = w_step & ((bus.up_down == CNT_UP) ? w_at_max : w_at_zero);
        w_count_nxt    = r_count;

        if (bus.load) begin
            w_count_nxt = w_load_clamped;
        end else if (w_step) begin
            if (bus.up_down == CNT_UP) begin
                if (w_at_max) begin
                    w_count_nxt = (bus.mode_sat == CNT_SAT) ? MAX_V : '0;
                end else begin
                    w_count_nxt = r_count + WIDTH'(1);
                end
            end else begin
                if (w_at_zero) begin
                    w_count_nxt = (bus.mode_sat == CNT_SAT) ? '0 : MAX_V;
                end else begin
                    w_count_nxt = r_count - WIDTH'(1);
                end
            end
        end

        // A boundary hit in the same cycle as clear_ovf keeps the flag set.
        w_ovf_nxt = w_boundary ? 1'b1 : (bus.clear_ovf ? 1'b0 : r_ovf);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_count <= '0;
            r_tc    <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            r_tc    <= w_boundary;
            r_ovf   <= w_ovf_nxt;
        end
    end

    assign bus.count = r_count;
    assign bus.tc    = r_tc;
    assign bus.ovf   = r_ovf;

endmodule

// File: tb/tb_updown_mod_counter.sv
// Directed bench for updown_mod_counter (WIDTH=4, MAX=9); a PRESCALE=4 instance is added under CNT_PRESCALE_EN.
module tb_updown_mod_counter;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    updown_mod_counter_if #(.WIDTH(4)) bus ();

`ifdef CNT_PRESCALE_EN
    updown_mod_counter_if #(.WIDTH(4)) bus4 ();

    updown_mod_counter #(.WIDTH(4), .MAX(9), .PRESCALE(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    updown_mod_counter #(.WIDTH(4), .MAX(9), .PRESCALE(4)) dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus4)
    );
`else
    updown_mod_counter #(.WIDTH(4), .MAX(9)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle; inputs change and outputs are sampled here.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset          = 1'b0;
        bus.load       = 1'b1;
        bus.load_value = 4'd7;
        bus.enable     = 1'b1;
        cyc();
        cyc();
        checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d want 0", bus.count); end
        checks++; if (bus.tc !== 1'b0)    begin errors++; $display("FAIL reset_tc got %0b want 0", bus.tc); end
        checks++; if (bus.ovf !== 1'b0)   begin errors++; $display("FAIL reset_ovf got %0b want 0", bus.ovf); end
        bus.load   = 1'b0;
        bus.enable = 1'b0;
        reset      = 1'b1;
    endtask

    task automatic test_wrap_up();
        logic [3:0] exp_cnt [10] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd0};
        bus.up_down  = 1'b1;
        bus.mode_sat = 1'b0;
        bus.enable   = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc();
            checks++; if (bus.count !== exp_cnt[i]) begin errors++; $display("FAIL wrap_count step %0d got %0d want %0d", i, bus.count, exp_cnt[i]); end
            checks++; if (bus.tc !== (i == 9))      begin errors++; $display("FAIL wrap_tc step %0d got %0b want %0b", i, bus.tc, (i == 9)); end
            checks++; if (bus.ovf !== (i == 9))     begin errors++; $display("FAIL wrap_ovf step %0d got %0b want %0b", i, bus.ovf, (i == 9)); end
        end
        cyc();
        checks++; if (bus.count !== 4'd1) begin errors++; $display("FAIL wrap_after_count got %0d want 1", bus.count); end
        checks++; if (bus.tc !== 1'b0)    begin errors++; $display("FAIL wrap_after_tc got %0b want 0", bus.tc); end
        checks++; if (bus.ovf !== 1'b1)   begin errors++; $display("FAIL wrap_sticky_ovf got %0b want 1", bus.ovf); end
        bus.enable = 1'b0;
    endtask

    task automatic test_sat_down();
        logic [3:0] exp_cnt [4] = '{4'd1, 4'd0, 4'd0, 4'd0};
        logic       exp_tc  [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        bus.load       = 1'b1;
        bus.load_value = 4'd2;
        bus.clear_ovf  = 1'b1;
        cyc();
        checks++; if (bus.count !== 4'd2) begin errors++; $display("FAIL sat_load_count got %0d want 2", bus.count); end
        checks++; if (bus.ovf !== 1'b0)   begin errors++; $display("FAIL sat_clear_ovf got %0b want 0", bus.ovf); end
        bus.load      = 1'b0;
        bus.clear_ovf = 1'b0;
        bus.up_down   = 1'b0;
        bus.mode_sat  = 1'b1;
        bus.enable    = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            checks++; if (bus.count !== exp_cnt[i]) begin errors++; $display("FAIL sat_count step %0d got %0d want %0d", i, bus.count, exp_cnt[i]); end
            checks++; if (bus.tc !== exp_tc[i])     begin errors++; $display("FAIL sat_tc step %0d got %0b want %0b", i, bus.tc, exp_tc[i]); end
            checks++; if (bus.ovf !== exp_tc[i])    begin errors++; $display("FAIL sat_ovf step %0d got %0b want %0b", i, bus.ovf, exp_tc[i]); end
        end
        bus.enable   = 1'b0;
        bus.mode_sat = 1'b0;
    endtask

    task automatic test_load_priority();
        bus.load       = 1'b1;
        bus.load_value = 4'd15;
        bus.enable     = 1'b1;
        bus.up_down    = 1'b1;
        cyc();
        checks++; if (bus.count !== 4'd9) begin errors++; $display("FAIL clamp_count got %0d want 9", bus.count); end
        checks++; if (bus.tc !== 1'b0)    begin errors++; $display("FAIL clamp_tc got %0b want 0", bus.tc); end
        reset = 1'b0;
        cyc();
        checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL reset_over_load_count got %0d want 0", bus.count); end
        checks++; if (bus.ovf !== 1'b0)   begin errors++; $display("FAIL reset_over_load_ovf got %0b want 0", bus.ovf); end
        reset      = 1'b1;
        bus.load   = 1'b0;
        bus.enable = 1'b0;
    endtask

    task automatic test_ovf_race();
        bus.load       = 1'b1;
        bus.load_value = 4'd9;
        cyc();
        bus.load      = 1'b0;
        bus.enable    = 1'b1;
        bus.up_down   = 1'b1;
        bus.mode_sat  = 1'b0;
        bus.clear_ovf = 1'b1;
        cyc();
        checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL race_count got %0d want 0", bus.count); end
        checks++; if (bus.tc !== 1'b1)    begin errors++; $display("FAIL race_tc got %0b want 1", bus.tc); end
        checks++; if (bus.ovf !== 1'b1)   begin errors++; $display("FAIL race_ovf_set_wins got %0b want 1", bus.ovf); end
        bus.enable = 1'b0;
        cyc();
        checks++; if (bus.ovf !== 1'b0)   begin errors++; $display("FAIL race_ovf_cleared got %0b want 0", bus.ovf); end
        checks++; if (bus.tc !== 1'b0)    begin errors++; $display("FAIL race_tc_drop got %0b want 0", bus.tc); end
        checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL race_hold_count got %0d want 0", bus.count); end
        bus.clear_ovf = 1'b0;
    endtask

    task automatic test_direction();
        logic [3:0] exp_dn [2] = '{4'd4, 4'd3};
        bus.up_down  = 1'b1;
        bus.mode_sat = 1'b0;
        bus.enable   = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            if (i == 3) bus.mode_sat = 1'b1;
            cyc();
            checks++; if (bus.count !== 4'(i)) begin errors++; $display("FAIL dir_up_count step %0d got %0d want %0d", i, bus.count, i); end
        end
        bus.up_down = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (i == 1) bus.mode_sat = 1'b0;
            cyc();
            checks++; if (bus.count !== exp_dn[i]) begin errors++; $display("FAIL dir_down_count step %0d got %0d want %0d", i, bus.count, exp_dn[i]); end
            checks++; if (bus.tc !== 1'b0)         begin errors++; $display("FAIL dir_tc step %0d got %0b want 0", i, bus.tc); end
        end
        bus.enable = 1'b0;
    endtask

    task automatic test_enable_gating();
        // count is 3 here; hold with enable low, then a wrap and tc drop on disable.
        bus.up_down = 1'b1;
        cyc();
        checks++; if (bus.count !== 4'd3) begin errors++; $display("FAIL gate_hold_count got %0d want 3", bus.count); end
        bus.load       = 1'b1;
        bus.load_value = 4'd9;
        cyc();
        bus.load   = 1'b0;
        bus.enable = 1'b1;
        cyc();
        checks++; if (bus.tc !== 1'b1)    begin errors++; $display("FAIL gate_wrap_tc got %0b want 1", bus.tc); end
        bus.enable = 1'b0;
        cyc();
        checks++; if (bus.tc !== 1'b0)    begin errors++; $display("FAIL gate_tc_drop got %0b want 0", bus.tc); end
        checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL gate_count_hold got %0d want 0", bus.count); end
        checks++; if (bus.ovf !== 1'b1)   begin errors++; $display("FAIL gate_ovf_hold got %0b want 1", bus.ovf); end
        bus.enable = 1'b1;
        cyc();
        checks++; if (bus.count !== 4'd1) begin errors++; $display("FAIL gate_resume_count got %0d want 1", bus.count); end
        bus.enable = 1'b0;
    endtask

`ifdef CNT_PRESCALE_EN
    task automatic test_prescaler();
        int k;
        k = 0;
        bus4.up_down  = 1'b1;
        bus4.mode_sat = 1'b0;
        for (int i = 0; i < 14; i++) begin
            bus4.enable = !(i == 6 || i == 7);
            cyc();
            if (bus4.enable) k++;
            checks++; if (bus4.count !== 4'(k / 4)) begin errors++; $display("FAIL presc_count cycle %0d got %0d want %0d", i, bus4.count, k / 4); end
        end
        checks++; if (bus4.count !== 4'd3) begin errors++; $display("FAIL presc_final got %0d want 3", bus4.count); end
        bus4.enable = 1'b0;
    endtask
`endif

    initial begin
        errors         = 0;
        checks         = 0;
        reset          = 1'b0;
        bus.enable     = 1'b0;
        bus.up_down    = 1'b1;
        bus.mode_sat   = 1'b0;
        bus.load       = 1'b0;
        bus.load_value = 4'd0;
        bus.clear_ovf  = 1'b0;
`ifdef CNT_PRESCALE_EN
        bus4.enable     = 1'b0;
        bus4.up_down    = 1'b1;
        bus4.mode_sat   = 1'b0;
        bus4.load       = 1'b0;
        bus4.load_value = 4'd0;
        bus4.clear_ovf  = 1'b0;
`endif
        #2;
        test_reset();
        test_wrap_up();
        test_sat_down();
        test_load_priority();
        test_ovf_race();
        test_direction();
        test_enable_gating();
`ifdef CNT_PRESCALE_EN
        test_prescaler();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
